// File: rtl/dot_product.sv
// dot_product: streaming fixed-point multiply-accumulate.
// Each accepted operand pair is multiplied and rescaled in stage P.
// Stage A sums the beats of a packet. The packet sum is placed in a
// result register that holds under downstream backpressure. A new
// packet may accumulate while an older result waits.
module dot_product #(
   parameter int ARGW = 16,
   parameter int FRAC = 8,
   parameter int RESW = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arg_valid,
   input  logic [2*ARGW-1:0] arg_data,
   input  logic              arg_last,
   output logic              arg_ready,
   output logic              res_valid,
   output logic [RESW-1:0]   res_data,
   input  logic              res_ready
);

   // Full-width signed product, arithmetically shifted right by FRAC
   // (rounds toward -inf), then truncated to the accumulator width.
   function automatic logic [RESW-1:0] scaled_product(
      input logic [ARGW-1:0] a,
      input logic [ARGW-1:0] b
   );
      logic signed [2*ARGW-1:0] a_ext;
      logic signed [2*ARGW-1:0] b_ext;
      logic signed [2*ARGW-1:0] full;
      a_ext = $signed({{ARGW{a[ARGW-1]}}, a});
      b_ext = $signed({{ARGW{b[ARGW-1]}}, b});
      full  = a_ext * b_ext;
      full  = full >>> FRAC;
      return full[RESW-1:0];
   endfunction

   // Stage P registers
   logic              p_valid_q, p_valid_d;
   logic              p_last_q,  p_last_d;
   logic [RESW-1:0]   p_data_q,  p_data_d;

   // Stage A registers
   logic [RESW-1:0]   acc_q,     acc_d;
   logic              first_q,   first_d;

   // Result register
   logic              res_valid_q, res_valid_d;
   logic [RESW-1:0]   res_data_q,  res_data_d;

   // Shared combinational terms
   logic              stall_s;
   logic              advance_s;
   logic [RESW-1:0]   base_s;
   logic [RESW-1:0]   sum_s;

   // Stall only when a last beat must load a result that is still held downstream.
   always_comb begin
      stall_s   = p_valid_q && p_last_q && res_valid_q && !res_ready;
      advance_s = p_valid_q && !stall_s;
      if (first_q) begin
         base_s = {RESW{1'b0}};
      end else begin
         base_s = acc_q;
      end
      sum_s     = base_s + p_data_q;
   end

   // Stage P next state: capture a new pair when not stalled, otherwise hold.
   always_comb begin
      p_valid_d = p_valid_q;
      p_last_d  = p_last_q;
      p_data_d  = p_data_q;
      if (!stall_s) begin
         p_valid_d = arg_valid;
         if (arg_valid) begin
            p_last_d = arg_last;
            p_data_d = scaled_product(arg_data[2*ARGW-1:ARGW], arg_data[ARGW-1:0]);
         end else begin
            p_last_d = 1'b0;
            p_data_d = p_data_q;
         end
      end else begin
         p_valid_d = p_valid_q;
      end
   end

   // Stage A and result next state: accumulate non-last beats, load result on last beat.
   always_comb begin
      acc_d       = acc_q;
      first_d     = first_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end else begin
         res_valid_d = res_valid_q;
      end
      if (advance_s) begin
         if (p_last_q) begin
            res_data_d  = sum_s;
            res_valid_d = 1'b1;
            first_d     = 1'b1;
         end else begin
            acc_d       = sum_s;
            first_d     = 1'b0;
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_valid_q   <= 1'b0;
         p_last_q    <= 1'b0;
         p_data_q    <= {RESW{1'b0}};
         acc_q       <= {RESW{1'b0}};
         first_q     <= 1'b1;
         res_valid_q <= 1'b0;
         res_data_q  <= {RESW{1'b0}};
      end else begin
         p_valid_q   <= p_valid_d;
         p_last_q    <= p_last_d;
         p_data_q    <= p_data_d;
         acc_q       <= acc_d;
         first_q     <= first_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   // arg_ready depends only on register state and res_ready, never on arg_valid.
   assign arg_ready = !stall_s;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_dot_product.sv
// Scoreboard bench for dot_product: directed packets push expected sums,
// a negedge monitor pops and compares on every result handshake.
module tb_dot_product;

   localparam int ARGW = 16;
   localparam int FRAC = 8;
   localparam int RESW = 24;

   logic             clk = 1'b0;
   logic             rst;
   logic             arg_valid;
   logic [2*ARGW-1:0] arg_data;
   logic             arg_last;
   logic             arg_ready;
   logic             res_valid;
   logic [RESW-1:0]  res_data;
   logic             res_ready;

   int n_cmp = 0;
   int n_err = 0;
   logic [RESW-1:0] exp_q[$];

   dot_product #(.ARGW(ARGW), .FRAC(FRAC), .RESW(RESW)) dut (
      .clk(clk), .rst(rst),
      .arg_valid(arg_valid), .arg_data(arg_data), .arg_last(arg_last), .arg_ready(arg_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [RESW-1:0] act, input logic [RESW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a handshake happens at the next posedge when valid && ready here.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got %h expected none", res_data);
         end else begin
            chk("res_data", res_data, exp_q.pop_front());
         end
      end
   end

   // Present one pair and hold it until accepted; waited reports any stall.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last, output bit waited);
      bit done;
      done      = 1'b0;
      waited    = 1'b0;
      arg_valid = 1'b1;
      arg_data  = {a, b};
      arg_last  = last;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (arg_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end else begin
            waited = 1'b1;
         end
      end
      arg_valid = 1'b0;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got no accept expected accept");
      end
   endtask

   // Wait until every expected result has been observed.
   task automatic drain();
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 100) begin
         @(posedge clk);
         i++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit w;
      rst       = 1'b1;
      res_ready = 1'b1;
      arg_valid = 1'b0;
      arg_data  = '0;
      arg_last  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_arg_ready", arg_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data",  res_data,  0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single beat and latency.
      exp_q.push_back(24'h000200);
      send(16'h0100, 16'h0200, 1'b1, w);
      @(negedge clk);
      chk("lat_edge_k", res_valid, 0);
      @(negedge clk);
      chk("lat_edge_k1", res_valid, 1);
      drain();

      // Three beats back-to-back.
      exp_q.push_back(24'h000280);
      send(16'h0100, 16'h0200, 1'b0, w); chk("b2b_ready0", w, 0);
      send(16'hff00, 16'h0080, 1'b0, w); chk("b2b_ready1", w, 0);
      send(16'h0040, 16'h0400, 1'b1, w); chk("b2b_ready2", w, 0);

      // Truncation toward -inf.
      exp_q.push_back(24'h000000);
      send(16'h0001, 16'h0001, 1'b1, w);
      exp_q.push_back(24'hffffff);
      send(16'hffff, 16'h0001, 1'b1, w);

      // Wrap-around accumulation.
      exp_q.push_back(24'hbffd00);
      send(16'h7fff, 16'h7fff, 1'b0, w);
      send(16'h7fff, 16'h7fff, 1'b0, w);
      send(16'h7fff, 16'h7fff, 1'b1, w);
      drain();

      // Backpressure: second last beat stalls behind held result.
      res_ready = 1'b0;
      exp_q.push_back(24'h000100);
      exp_q.push_back(24'h000200);
      send(16'h0100, 16'h0100, 1'b1, w);
      send(16'h0100, 16'h0200, 1'b1, w);
      @(negedge clk);
      chk("stall_arg_ready", arg_ready, 0);
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res_data",  res_data,  24'h000100);
      repeat (3) @(negedge clk);
      chk("stall_hold_ready", arg_ready, 0);
      chk("stall_hold_data",  res_data,  24'h000100);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      drain();

      // Reset mid-packet discards the partial sum.
      send(16'h0100, 16'h0100, 1'b0, w);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_arg_ready", arg_ready, 1);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_res_data",  res_data,  0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.push_back(24'h000300);
      send(16'h0100, 16'h0300, 1'b1, w);
      drain();

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
